serial_add_sub: RTL and testbench

//  Bit-serial add/subtract engine that drives the single-bit full_adder stage, LSB first.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/serial_add_sub_if.sv | 38 +++
 rtl/full_adder.sv | 15 +
 rtl/serial_add_sub.sv | 161 ++++++++++++++++
 tb/tb_serial_add_sub.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: engine FSM states, operation codes,
// default datapath width and the carry (majority) helper.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD     = 1'b0;
    localparam logic OP_SUB     = 1'b1;
    localparam int   CALC_WIDTH = 8;

    // Majority of three bits: carry out of a single full-adder stage.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// Handshake bundle between the calculator front end and the bit-serial
// add/subtract engine. The ovf signal exists only when the build defines
// SERIAL_ADD_SUB_OVF_EN.
interface serial_add_sub_if
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start_valid, a, b, sub, res_ready,
        input  start_ready, res_valid, result, cout
`ifdef SERIAL_ADD_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start_valid, a, b, sub, res_ready,
        output start_ready, res_valid, result, cout
`ifdef SERIAL_ADD_SUB_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder stage: s = a^b^cin, cout = majority(a,b,cin).
module full_adder
    import calc_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = maj3(a, b, cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract engine. Operands are latched on the start
// handshake, processed LSB first through one full_adder stage with the
// carry held in a register, and the sum is shifted into the result register
// from the MSB side. Result, final carry and (with SERIAL_ADD_SUB_OVF_EN)
// signed overflow are presented on a valid/ready handshake.
// Subtraction is A + ~B + 1: B is inverted at accept and carry seeds to 1.
module serial_add_sub
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
)
(
    input  logic           clk,
    input  logic           rst_n,
    serial_add_sub_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state_r;
    state_t             state_d;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               carry_r;
    logic [WIDTH-1:0]   result_r;
    logic               cout_r;
    logic               res_valid_r;
    logic               res_valid_d;
    logic               start_ready_r;
    logic               start_ready_d;
    logic               accept_s;
    logic               last_bit_s;
    logic               a_bit_s;
    logic               b_bit_s;
    logic               fa_sum_s;
    logic               fa_cout_s;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic               ovf_r;
`endif

    assign a_bit_s = a_r[cnt_r];
    assign b_bit_s = b_r[cnt_r];

    full_adder u_fa (
        .a    (a_bit_s),
        .b    (b_bit_s),
        .cin  (carry_r),
        .s    (fa_sum_s),
        .cout (fa_cout_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_d;
        end
    end

    // Next-state decode plus next values of the registered handshake outputs.
    always_comb begin
        state_d       = state_r;
        accept_s      = 1'b0;
        last_bit_s    = 1'b0;
        res_valid_d   = 1'b0;
        start_ready_d = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start_valid && start_ready_r) begin
                    accept_s = 1'b1;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    last_bit_s = 1'b1;
                    state_d    = DONE;
                end else begin
                    state_d    = RUN;
                end
            end
            DONE: begin
                if (res_valid_r && bus.res_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // res_valid follows one edge after entering DONE, giving WIDTH+1 edges
        // from accept; it drops on the same edge the handshake completes.
        if ((state_r == DONE) && (state_d == DONE)) begin
            res_valid_d = 1'b1;
        end else begin
            res_valid_d = 1'b0;
        end
        if (state_d == IDLE) begin
            start_ready_d = 1'b1;
        end else begin
            start_ready_d = 1'b0;
        end
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r   <= 1'b0;
            start_ready_r <= 1'b1;
        end else begin
            res_valid_r   <= res_valid_d;
            start_ready_r <= start_ready_d;
        end
    end

    // Operand latch, bit counter, carry chain and result shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            carry_r  <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
            ovf_r    <= 1'b0;
`endif
        end else if (accept_s) begin
            a_r     <= bus.a;
            b_r     <= (bus.sub == OP_SUB) ? ~bus.b : bus.b;
            carry_r <= bus.sub;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (state_r == RUN) begin
            result_r <= {fa_sum_s, result_r[WIDTH-1:1]};
            carry_r  <= fa_cout_s;
            cnt_r    <= cnt_r + CNT_W'(1);
            if (last_bit_s) begin
                cout_r <= fa_cout_s;
`ifdef SERIAL_ADD_SUB_OVF_EN
                // carry_r here is the carry into the MSB.
                ovf_r  <= carry_r ^ fa_cout_s;
`endif
            end
        end
    end

    assign bus.start_ready = start_ready_r;
    assign bus.res_valid   = res_valid_r;
    assign bus.result      = result_r;
    assign bus.cout        = cout_r;
`ifdef SERIAL_ADD_SUB_OVF_EN
    assign bus.ovf         = ovf_r;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and random bench for serial_add_sub at WIDTH=8. Checks ovf when
// SERIAL_ADD_SUB_OVF_EN is defined.
module tb_serial_add_sub;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    serial_add_sub_if #(.WIDTH(W)) sif ();

    serial_add_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] r;
        logic       c;
        logic       v;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s);
        @(negedge clk);
        check("start_ready_idle", 32'(sif.start_ready), 32'd1);
        sif.start_valid = 1'b1;
        sif.a   = a;
        sif.b   = b;
        sif.sub = s;
        @(posedge clk);
        #1;
        sif.start_valid = 1'b0;
        sif.a   = 8'($urandom);
        sif.b   = 8'($urandom);
        sif.sub = 1'($urandom);
    endtask

    task automatic wait_result();
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!sif.res_valid && lat < 40);
        check("latency", 32'(lat), 32'd9);
    endtask

    task automatic check_outputs(input logic [7:0] r, input logic c, input logic v);
        check("result", 32'(sif.result), 32'(r));
        check("cout", 32'(sif.cout), 32'(c));
`ifdef SERIAL_ADD_SUB_OVF_EN
        check("ovf", 32'(sif.ovf), 32'(v));
`else
        if (v !== v) check("ovf_x", 32'd0, 32'd1);
`endif
    endtask

    task automatic retire();
        sif.res_ready = 1'b1;
        @(posedge clk);
        #1;
        sif.res_ready = 1'b0;
        check("res_valid_drop", 32'(sif.res_valid), 32'd0);
        check("start_ready_back", 32'(sif.start_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;
        logic [7:0] er;
        logic       ec;
        logic       ev;
        logic [7:0] held;

        tests = 0;
        fails = 0;
        vecs[0]  = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3]  = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4]  = '{8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[5]  = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[6]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[8]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[9]  = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[10] = '{8'h55, 8'h55, 1'b0, 8'hAA, 1'b0, 1'b1};
        vecs[11] = '{8'h00, 8'h80, 1'b1, 8'h80, 1'b0, 1'b1};

        sif.start_valid = 1'b0;
        sif.a = 8'h00;
        sif.b = 8'h00;
        sif.sub = 1'b0;
        sif.res_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start_ready", 32'(sif.start_ready), 32'd1);
        check("rst_res_valid", 32'(sif.res_valid), 32'd0);
        check_outputs(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sub);
            check("start_ready_run", 32'(sif.start_ready), 32'd0);
            wait_result();
            check("start_ready_done", 32'(sif.start_ready), 32'd0);
            check_outputs(vecs[i].r, vecs[i].c, vecs[i].v);
            retire();
        end

        // Back-pressure in DONE, ignored start, then release.
        start_op(8'h07, 8'h05, 1'b1);
        wait_result();
        held = sif.result;
        repeat (5) @(posedge clk);
        #1;
        check("hold_result", 32'(sif.result), 32'h02);
        check("hold_valid", 32'(sif.res_valid), 32'd1);
        check("hold_start_ready", 32'(sif.start_ready), 32'd0);
        sif.start_valid = 1'b1;
        sif.a = 8'h11;
        sif.b = 8'h22;
        sif.sub = 1'b0;
        @(posedge clk);
        #1;
        sif.start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("ignored_start_result", 32'(sif.result), 32'(held));
        check("ignored_start_valid", 32'(sif.res_valid), 32'd1);
        check("ignored_start_ready", 32'(sif.start_ready), 32'd0);
        retire();
        check("held_after_retire", 32'(sif.result), 32'h02);
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_valid", 32'(sif.res_valid), 32'd0);

        // Reset in the middle of RUN.
        start_op(8'hAA, 8'h55, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_result", 32'(sif.result), 32'h00);
        check("midrst_cout", 32'(sif.cout), 32'd0);
        check("midrst_valid", 32'(sif.res_valid), 32'd0);
        check("midrst_ready", 32'(sif.start_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(8'h12, 8'h34, 1'b0);
        wait_result();
        check_outputs(8'h46, 1'b0, 1'b0);
        retire();

        // Random operations against an independent golden model.
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            if (rs) begin
                er = ra - rb;
                ec = (ra >= rb) ? 1'b1 : 1'b0;
                ev = (ra[7] != rb[7]) && (er[7] != ra[7]);
            end else begin
                er = ra + rb;
                ec = ((9'(ra) + 9'(rb)) > 9'd255) ? 1'b1 : 1'b0;
                ev = (ra[7] == rb[7]) && (er[7] != ra[7]);
            end
            start_op(ra, rb, rs);
            wait_result();
            check_outputs(er, ec, ev);
            retire();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
